// File: rtl/pcim_pkg.sv
// pcim_pkg: shared response codes, FSM states and address helpers for pcim_responder
package pcim_pkg;
    localparam logic [1:0] OKAY   = 2'b00;
    localparam logic [1:0] SLVERR = 2'b10;

    typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_t;
    typedef enum logic {R_IDLE, R_DATA} r_state_t;

    function automatic int lsb_of(input int data_w);
        return $clog2(data_w / 8);
    endfunction
endpackage

// File: rtl/pcim_resp_mem.sv
// pcim_resp_mem: word memory with one byte-strobed write port and one registered read port
module pcim_resp_mem #(
    parameter int DATA_W = 512,
    parameter int DEPTH  = 1024
) (
    input  logic                       clk,
    input  logic                       we,
    input  logic [$clog2(DEPTH)-1:0]   wr_idx,
    input  logic [DATA_W-1:0]          wr_data,
    input  logic [DATA_W/8-1:0]        wr_strb,
    input  logic                       re,
    input  logic [$clog2(DEPTH)-1:0]   rd_idx,
    output logic [DATA_W-1:0]          rd_data
);
    logic [DATA_W-1:0] mem [DEPTH];

    // both ports update on the same edge, so a colliding read returns the old word
    always_ff @(posedge clk) begin
        if (we)
            for (int b = 0; b < DATA_W / 8; b++)
                if (wr_strb[b]) mem[wr_idx][b*8 +: 8] <= wr_data[b*8 +: 8];
        if (re) rd_data <= mem[rd_idx];
    end
endmodule

// File: rtl/pcim_responder.sv
// pcim_responder: AXI4 slave terminating a PCIM master port onto an on-chip word memory
module pcim_responder
    import pcim_pkg::*;
#(
    parameter int DATA_W = 512,
    parameter int ADDR_W = 64,
    parameter int ID_W   = 16,
    parameter int DEPTH  = 1024
) (
    input  logic                  clk_main_a0,
    input  logic                  rst_main,
    input  logic [ID_W-1:0]       pcim_awid,
    input  logic [ADDR_W-1:0]     pcim_awaddr,
    input  logic [7:0]            pcim_awlen,
    input  logic [2:0]            pcim_awsize,
    input  logic                  pcim_awvalid,
    output logic                  pcim_awready,
    input  logic [DATA_W-1:0]     pcim_wdata,
    input  logic [DATA_W/8-1:0]   pcim_wstrb,
    input  logic                  pcim_wlast,
    input  logic                  pcim_wvalid,
    output logic                  pcim_wready,
    output logic [ID_W-1:0]       pcim_bid,
    output logic [1:0]            pcim_bresp,
    output logic                  pcim_bvalid,
    input  logic                  pcim_bready,
    input  logic [ID_W-1:0]       pcim_arid,
    input  logic [ADDR_W-1:0]     pcim_araddr,
    input  logic [7:0]            pcim_arlen,
    input  logic [2:0]            pcim_arsize,
    input  logic                  pcim_arvalid,
    output logic                  pcim_arready,
    output logic [ID_W-1:0]       pcim_rid,
    output logic [DATA_W-1:0]     pcim_rdata,
    output logic [1:0]            pcim_rresp,
    output logic                  pcim_rlast,
    output logic                  pcim_rvalid,
    input  logic                  pcim_rready
);
    localparam int LSB = lsb_of(DATA_W);
    localparam int IW  = $clog2(DEPTH);
    localparam logic [2:0] SIZE = 3'(LSB);

    w_state_t        wstate;
    logic [7:0]      wlen, wcnt;
    logic [IW-1:0]   widx;
    logic            werr;
    r_state_t        rstate;
    logic [7:0]      rlen, rbeat;
    logic [IW-1:0]   ridx;
    logic [DATA_W-1:0] mem_q;
    logic            aw_hs, w_hs, ar_hs, r_hs, beat_err, mem_we, mem_re;
    logic [IW-1:0]   mem_ridx;
    logic            unused;

    assign unused   = ^{pcim_awaddr, pcim_araddr};
    assign aw_hs    = pcim_awvalid && pcim_awready;
    assign w_hs     = pcim_wvalid && pcim_wready;
    assign ar_hs    = pcim_arvalid && pcim_arready;
    assign r_hs     = pcim_rvalid && pcim_rready;
    assign beat_err = pcim_wlast != (wcnt == wlen);
    assign mem_we   = w_hs && !werr && !beat_err;
    assign mem_re   = ar_hs || (r_hs && !pcim_rlast);
    assign mem_ridx = ar_hs ? pcim_araddr[LSB +: IW] : ridx + IW'(1);
    assign pcim_rdata = (pcim_rvalid && pcim_rresp == OKAY) ? mem_q : '0;

    pcim_resp_mem #(.DATA_W(DATA_W), .DEPTH(DEPTH)) u_mem (
        .clk     (clk_main_a0),
        .we      (mem_we),
        .wr_idx  (widx),
        .wr_data (pcim_wdata),
        .wr_strb (pcim_wstrb),
        .re      (mem_re),
        .rd_idx  (mem_ridx),
        .rd_data (mem_q)
    );

    // a burst of the wrong length is drained until wlast, then answered with SLVERR
    always_ff @(posedge clk_main_a0) begin
        if (rst_main) begin
            wstate       <= W_IDLE;
            pcim_awready <= 1'b0;
            pcim_wready  <= 1'b0;
            pcim_bvalid  <= 1'b0;
            pcim_bresp   <= OKAY;
            pcim_bid     <= '0;
        end else begin
            case (wstate)
                W_IDLE: begin
                    pcim_awready <= !aw_hs;
                    if (aw_hs) begin
                        wstate      <= W_DATA;
                        pcim_wready <= 1'b1;
                        pcim_bid    <= pcim_awid;
                        widx        <= pcim_awaddr[LSB +: IW];
                        wlen        <= pcim_awlen;
                        wcnt        <= '0;
                        werr        <= pcim_awsize != SIZE;
                    end
                end
                W_DATA: if (w_hs) begin
                    werr <= werr || beat_err;
                    wcnt <= wcnt + 8'd1;
                    widx <= widx + IW'(1);
                    if (pcim_wlast) begin
                        wstate      <= W_RESP;
                        pcim_wready <= 1'b0;
                        pcim_bvalid <= 1'b1;
                        pcim_bresp  <= (werr || beat_err) ? SLVERR : OKAY;
                    end
                end
                W_RESP: if (pcim_bready) begin
                    wstate       <= W_IDLE;
                    pcim_bvalid  <= 1'b0;
                    pcim_awready <= 1'b1;
                end
                default: wstate <= W_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk_main_a0) begin
        if (rst_main) begin
            rstate       <= R_IDLE;
            pcim_arready <= 1'b0;
            pcim_rvalid  <= 1'b0;
            pcim_rlast   <= 1'b0;
            pcim_rresp   <= OKAY;
            pcim_rid     <= '0;
        end else begin
            case (rstate)
                R_IDLE: begin
                    pcim_arready <= !ar_hs;
                    if (ar_hs) begin
                        rstate      <= R_DATA;
                        pcim_rvalid <= 1'b1;
                        pcim_rid    <= pcim_arid;
                        pcim_rresp  <= (pcim_arsize != SIZE) ? SLVERR : OKAY;
                        pcim_rlast  <= pcim_arlen == 8'd0;
                        rlen        <= pcim_arlen;
                        rbeat       <= '0;
                        ridx        <= pcim_araddr[LSB +: IW];
                    end
                end
                R_DATA: if (r_hs) begin
                    if (pcim_rlast) begin
                        rstate       <= R_IDLE;
                        pcim_rvalid  <= 1'b0;
                        pcim_rlast   <= 1'b0;
                        pcim_arready <= 1'b1;
                    end else begin
                        rbeat      <= rbeat + 8'd1;
                        ridx       <= ridx + IW'(1);
                        pcim_rlast <= (rbeat + 8'd1) == rlen;
                    end
                end
                default: rstate <= R_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_pcim_responder.sv
// tb_pcim_responder: directed stimulus with a queue scoreboard checked by a decoupled monitor
module tb_pcim_responder;
    localparam int DATA_W = 512, ADDR_W = 64, ID_W = 16, DEPTH = 1024, NB = DATA_W / 8;
    localparam int LSB = 6, IW = 10;
    localparam logic [1:0] OK = 2'b00, SE = 2'b10;
    localparam logic [2:0] SZ = 3'd6;

    logic clk, rst_main;
    logic [ID_W-1:0] pcim_awid, pcim_bid, pcim_arid, pcim_rid;
    logic [ADDR_W-1:0] pcim_awaddr, pcim_araddr;
    logic [7:0] pcim_awlen, pcim_arlen;
    logic [2:0] pcim_awsize, pcim_arsize;
    logic pcim_awvalid, pcim_awready, pcim_wlast, pcim_wvalid, pcim_wready;
    logic pcim_bvalid, pcim_bready, pcim_arvalid, pcim_arready;
    logic pcim_rlast, pcim_rvalid, pcim_rready;
    logic [DATA_W-1:0] pcim_wdata, pcim_rdata;
    logic [NB-1:0] pcim_wstrb;
    logic [1:0] pcim_bresp, pcim_rresp;

    typedef struct packed {logic [DATA_W-1:0] d; logic [1:0] resp; logic last; logic [ID_W-1:0] id;} rexp_t;
    typedef struct packed {logic [1:0] resp; logic [ID_W-1:0] id;} bexp_t;
    rexp_t exp_r[$];
    bexp_t exp_b[$];
    logic [DATA_W-1:0] model [DEPTH];
    int checks = 0, failures = 0;

    pcim_responder dut (
        .clk_main_a0(clk), .rst_main(rst_main),
        .pcim_awid(pcim_awid), .pcim_awaddr(pcim_awaddr), .pcim_awlen(pcim_awlen),
        .pcim_awsize(pcim_awsize), .pcim_awvalid(pcim_awvalid), .pcim_awready(pcim_awready),
        .pcim_wdata(pcim_wdata), .pcim_wstrb(pcim_wstrb), .pcim_wlast(pcim_wlast),
        .pcim_wvalid(pcim_wvalid), .pcim_wready(pcim_wready),
        .pcim_bid(pcim_bid), .pcim_bresp(pcim_bresp), .pcim_bvalid(pcim_bvalid), .pcim_bready(pcim_bready),
        .pcim_arid(pcim_arid), .pcim_araddr(pcim_araddr), .pcim_arlen(pcim_arlen),
        .pcim_arsize(pcim_arsize), .pcim_arvalid(pcim_arvalid), .pcim_arready(pcim_arready),
        .pcim_rid(pcim_rid), .pcim_rdata(pcim_rdata), .pcim_rresp(pcim_rresp),
        .pcim_rlast(pcim_rlast), .pcim_rvalid(pcim_rvalid), .pcim_rready(pcim_rready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: got no finish, required finish within 500us");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [DATA_W-1:0] act, input logic [DATA_W-1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h required %0h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (!rst_main && pcim_rvalid) begin
            if (exp_r.size() == 0) begin
                checks++; failures++;
                $display("FAIL r_unexpected: got rvalid=1 required no beat pending");
            end else begin
                chk("rdata", pcim_rdata, exp_r[0].d);
                chk("rresp", DATA_W'(pcim_rresp), DATA_W'(exp_r[0].resp));
                chk("rlast", DATA_W'(pcim_rlast), DATA_W'(exp_r[0].last));
                chk("rid", DATA_W'(pcim_rid), DATA_W'(exp_r[0].id));
                if (pcim_rready) void'(exp_r.pop_front());
            end
        end
        if (!rst_main && pcim_bvalid) begin
            if (exp_b.size() == 0) begin
                checks++; failures++;
                $display("FAIL b_unexpected: got bvalid=1 required no response pending");
            end else begin
                chk("bresp", DATA_W'(pcim_bresp), DATA_W'(exp_b[0].resp));
                chk("bid", DATA_W'(pcim_bid), DATA_W'(exp_b[0].id));
                if (pcim_bready) void'(exp_b.pop_front());
            end
        end
    end

    function automatic logic rdy(input int k);
        return k == 0 ? pcim_awready : k == 1 ? pcim_wready : pcim_arready;
    endfunction

    task automatic hs_wait(input int k);
        for (int c = 0; c < 100; c++) begin
            @(negedge clk);
            if (rdy(k)) begin
                @(posedge clk); #1;
                return;
            end
        end
        checks++; failures++;
        $display("FAIL hs_timeout_%0d: got no ready, required ready within 100 cycles", k);
    endtask

    task automatic wait_b();
        for (int c = 0; c < 100; c++) begin
            @(negedge clk); #1;
            if (exp_b.size() == 0) begin
                @(posedge clk); #1;
                return;
            end
        end
        checks++; failures++;
        $display("FAIL b_timeout: got %0d pending, required 0", exp_b.size());
    endtask

    task automatic drain_r(input bit toggle, input bit nobubble);
        for (int c = 0; c < 200; c++) begin
            pcim_rready = toggle ? ~pcim_rready : 1'b1;
            @(negedge clk); #1;
            if (nobubble) chk("r_nobubble", DATA_W'(pcim_rvalid), DATA_W'(1));
            if (exp_r.size() == 0) begin
                @(posedge clk); #1;
                pcim_rready = 1'b1;
                return;
            end
            @(posedge clk); #1;
        end
        checks++; failures++;
        $display("FAIL r_timeout: got %0d pending, required 0", exp_r.size());
    endtask

    task automatic wr_burst(input logic [ID_W-1:0] id, input logic [ADDR_W-1:0] addr, input logic [7:0] len,
                            input logic [2:0] size, input int nbeats, input int last_at,
                            input logic [DATA_W-1:0] d0, input bit incr, input logic [NB-1:0] strb,
                            input logic [1:0] resp);
        logic [DATA_W-1:0] d;
        int idx;
        idx = int'(addr[LSB +: IW]);
        exp_b.push_back(bexp_t'{resp, id});
        if (resp == OK)
            for (int b = 0; b <= int'(len); b++) begin
                d = incr ? d0 + DATA_W'(b) : d0;
                for (int y = 0; y < NB; y++)
                    if (strb[y]) model[(idx + b) % DEPTH][y*8 +: 8] = d[y*8 +: 8];
            end
        pcim_awid = id; pcim_awaddr = addr; pcim_awlen = len; pcim_awsize = size; pcim_awvalid = 1'b1;
        hs_wait(0);
        pcim_awvalid = 1'b0;
        for (int b = 0; b < nbeats; b++) begin
            pcim_wdata = incr ? d0 + DATA_W'(b) : d0;
            pcim_wstrb = strb;
            pcim_wlast = (b == last_at);
            pcim_wvalid = 1'b1;
            hs_wait(1);
        end
        pcim_wvalid = 1'b0; pcim_wlast = 1'b0;
        if (pcim_bready) wait_b();
    endtask

    task automatic rd_burst(input logic [ID_W-1:0] id, input logic [ADDR_W-1:0] addr, input logic [7:0] len,
                            input logic [2:0] size, input bit use_model, input logic [DATA_W-1:0] exp0);
        rexp_t e;
        int idx;
        idx = int'(addr[LSB +: IW]);
        for (int b = 0; b <= int'(len); b++) begin
            e.d = (size != SZ) ? '0 : use_model ? model[(idx + b) % DEPTH] : exp0;
            e.resp = (size != SZ) ? SE : OK;
            e.last = (b == int'(len));
            e.id = id;
            exp_r.push_back(e);
        end
        pcim_arid = id; pcim_araddr = addr; pcim_arlen = len; pcim_arsize = size; pcim_arvalid = 1'b1;
        hs_wait(2);
        pcim_arvalid = 1'b0;
    endtask

    initial begin
        rst_main = 1'b1;
        {pcim_awid, pcim_awaddr, pcim_awlen, pcim_awsize, pcim_awvalid} = '0;
        {pcim_wdata, pcim_wstrb, pcim_wlast, pcim_wvalid} = '0;
        {pcim_arid, pcim_araddr, pcim_arlen, pcim_arsize, pcim_arvalid} = '0;
        pcim_bready = 1'b1; pcim_rready = 1'b1;
        @(posedge clk); #1;
        @(negedge clk);
        chk("rst_awready", DATA_W'(pcim_awready), '0);
        chk("rst_wready", DATA_W'(pcim_wready), '0);
        chk("rst_bvalid", DATA_W'(pcim_bvalid), '0);
        chk("rst_bresp", DATA_W'(pcim_bresp), '0);
        chk("rst_bid", DATA_W'(pcim_bid), '0);
        chk("rst_arready", DATA_W'(pcim_arready), '0);
        chk("rst_rvalid", DATA_W'(pcim_rvalid), '0);
        chk("rst_rlast", DATA_W'(pcim_rlast), '0);
        chk("rst_rresp", DATA_W'(pcim_rresp), '0);
        chk("rst_rid", DATA_W'(pcim_rid), '0);
        chk("rst_rdata", pcim_rdata, '0);
        @(posedge clk); #1;
        rst_main = 1'b0;
        @(negedge clk);
        chk("awready_before_rise", DATA_W'(pcim_awready), '0);
        @(negedge clk);
        chk("awready_rise", DATA_W'(pcim_awready), DATA_W'(1));
        chk("arready_rise", DATA_W'(pcim_arready), DATA_W'(1));
        @(posedge clk); #1;

        // single beat write and read back
        wr_burst(16'h1234, 64'h40, 8'd0, SZ, 1, 0, {64{8'hA5}}, 1'b0, '1, OK);
        rd_burst(16'h0BEE, 64'h40, 8'd0, SZ, 1'b0, {64{8'hA5}});
        drain_r(1'b0, 1'b1);

        // wrapping 8-beat burst; upper and offset address bits must be ignored
        wr_burst(16'h0002, 64'hDEAD_0000_0000_FF85, 8'd7, SZ, 8, 7, '0, 1'b1, '1, OK);
        rd_burst(16'h0003, 64'hFF80, 8'd7, SZ, 1'b1, '0);
        drain_r(1'b0, 1'b1);
        rd_burst(16'h0004, 64'h0, 8'd0, SZ, 1'b0, DATA_W'(2));
        drain_r(1'b0, 1'b0);
        rd_burst(16'h0005, 64'h40, 8'd0, SZ, 1'b0, DATA_W'(3));
        drain_r(1'b0, 1'b0);

        // partial strobe over a preloaded word
        wr_burst(16'h0006, 64'h280, 8'd0, SZ, 1, 0, {64{8'hFF}}, 1'b0, '1, OK);
        wr_burst(16'h0006, 64'h280, 8'd0, SZ, 1, 0, {64{8'h11}}, 1'b0, NB'(1), OK);
        rd_burst(16'h0007, 64'h280, 8'd0, SZ, 1'b0, {{63{8'hFF}}, 8'h11});
        drain_r(1'b0, 1'b0);

        // short burst: wlast on the first of four beats
        wr_burst(16'h0008, 64'h500, 8'd0, SZ, 1, 0, {64{8'h3C}}, 1'b0, '1, OK);
        wr_burst(16'h0009, 64'h500, 8'd3, SZ, 1, 0, {64{8'hEE}}, 1'b0, '1, SE);
        rd_burst(16'h000A, 64'h500, 8'd0, SZ, 1'b0, {64{8'h3C}});
        drain_r(1'b0, 1'b0);

        // long burst: len 0 but wlast only on the third beat
        wr_burst(16'h000B, 64'h540, 8'd1, SZ, 2, 1, {64{8'h5A}}, 1'b0, '1, OK);
        wr_burst(16'h000C, 64'h540, 8'd0, SZ, 3, 2, {64{8'hC3}}, 1'b0, '1, SE);
        rd_burst(16'h000D, 64'h540, 8'd0, SZ, 1'b0, {64{8'h5A}});
        drain_r(1'b0, 1'b0);
        rd_burst(16'h000E, 64'h580, 8'd0, SZ, 1'b0, {64{8'h5A}});
        drain_r(1'b0, 1'b0);

        // illegal sizes
        wr_burst(16'h000F, 64'h780, 8'd0, SZ, 1, 0, {64{8'h77}}, 1'b0, '1, OK);
        wr_burst(16'h0010, 64'h780, 8'd0, 3'd2, 1, 0, {64{8'h99}}, 1'b0, '1, SE);
        rd_burst(16'h0011, 64'h780, 8'd0, SZ, 1'b0, {64{8'h77}});
        drain_r(1'b0, 1'b0);
        rd_burst(16'h0012, 64'h780, 8'd1, 3'd2, 1'b1, '0);
        drain_r(1'b0, 1'b0);

        // B backpressure: response must hold while bready is low
        pcim_bready = 1'b0;
        wr_burst(16'h5A5A, 64'h780, 8'd0, SZ, 1, 0, {64{8'h42}}, 1'b0, '1, OK);
        repeat (5) begin
            @(negedge clk); #1;
            chk("bvalid_hold", DATA_W'(pcim_bvalid), DATA_W'(1));
        end
        @(posedge clk); #1;
        pcim_bready = 1'b1;
        wait_b();
        rd_burst(16'h0013, 64'h780, 8'd0, SZ, 1'b0, {64{8'h42}});
        drain_r(1'b0, 1'b0);

        // R backpressure with toggling rready
        rd_burst(16'h0014, 64'hFF80, 8'd3, SZ, 1'b1, '0);
        drain_r(1'b1, 1'b0);

        // reset in the middle of a read burst
        rd_burst(16'h0015, 64'h0, 8'd3, SZ, 1'b1, '0);
        @(posedge clk); #1;
        pcim_rready = 1'b0;
        rst_main = 1'b1;
        @(posedge clk); #1;
        exp_r.delete();
        @(negedge clk);
        chk("rst_mid_rvalid", DATA_W'(pcim_rvalid), '0);
        chk("rst_mid_rdata", pcim_rdata, '0);
        @(posedge clk); #1;
        rst_main = 1'b0;
        @(posedge clk);
        @(negedge clk);
        chk("rst_mid_arready", DATA_W'(pcim_arready), DATA_W'(1));
        @(posedge clk); #1;
        pcim_rready = 1'b1;
        rd_burst(16'h0016, 64'hFF80, 8'd7, SZ, 1'b1, '0);
        drain_r(1'b0, 1'b1);
        rd_burst(16'h0017, 64'h280, 8'd0, SZ, 1'b0, {{63{8'hFF}}, 8'h11});
        drain_r(1'b0, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
